// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the three-way memory port arbiter.
// Requester k drives Mux3 select value k.
package arb_pkg;

    localparam int unsigned NUM_REQ = 3;

    typedef enum logic [0:0] {
        IDLE,
        BUSY
    } arb_state_t;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant handshake and memory-side strobes between requesters and the arbiter.
// The arbiter uses the slave modport; requesters and the memory side use master.
interface mem_port_arbiter_if import arb_pkg::*; ();

    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] grant_o;
    logic [NUM_REQ-1:0] done_o;
    logic [NUM_REQ-1:0] err_o;
    logic [1:0]         sel_o;
    logic               mem_valid_o;
    logic               mem_ready_i;

    modport slave (
        input  req_i,
        input  mem_ready_i,
        output grant_o,
        output done_o,
        output err_o,
        output sel_o,
        output mem_valid_o
    );

    modport master (
        output req_i,
        output mem_ready_i,
        input  grant_o,
        input  done_o,
        input  err_o,
        input  sel_o,
        input  mem_valid_o
    );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: searches from (last+1) mod 3 upward, wrapping,
// and returns the first pending requester.
module rr_picker import arb_pkg::*; (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic               any_req,
    output logic [1:0]         winner,
    output logic [NUM_REQ-1:0] onehot
);

    logic [1:0] start;
    logic [2:0] idx;

    always_comb begin
        any_req = |req;
        winner  = SEL_REQ0;
        idx     = 3'd0;
        unique case (last)
            SEL_REQ0: start = SEL_REQ1;
            SEL_REQ1: start = SEL_REQ2;
            default:  start = SEL_REQ0;
        endcase
        // Walk the ring backwards so the requester nearest to start is written last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, start} + 3'(i);
            if (idx >= 3'(NUM_REQ)) begin
                idx = idx - 3'(NUM_REQ);
            end
            if (req[idx[1:0]]) begin
                winner = idx[1:0];
            end
        end
        onehot = any_req ? (3'b001 << winner) : 3'b000;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a single-ported memory shared by fetch, LSU and debug/DMA,
// with a watchdog that aborts a transaction the memory never completes.
module mem_port_arbiter import arb_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [1:0]           sel_q, sel_d;
    logic [1:0]           last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   done, err;
    logic                 any_req;
    logic [1:0]           pick;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic                 timeout;

    rr_picker u_picker (
        .req     (bus.req_i),
        .last    (last_q),
        .any_req (any_req),
        .winner  (pick),
        .onehot  (pick_onehot)
    );

    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        done    = '0;
        err     = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    grant_d = pick_onehot;
                    sel_d   = pick;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // Completion wins over a coincident timeout.
                if (bus.mem_ready_i || timeout) begin
                    if (bus.mem_ready_i) begin
                        done = grant_q;
                    end else begin
                        err = grant_q;
                    end
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = sel_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= SEL_REQ0;
            last_q  <= SEL_REQ2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant_o     = grant_q;
    assign bus.sel_o       = sel_q;
    assign bus.mem_valid_o = |grant_q;
    assign bus.done_o      = done;
    assign bus.err_o       = err;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-ported memory between three requesters:
  - req 0: instruction fetch
  - req 1: load/store unit
  - req 2: debug/DMA port
- Runs a round-robin request/grant handshake and drives the 2-bit select that steers the address/wdata Mux3 instances in front of the memory.
- Tracks one outstanding memory transaction at a time, with a watchdog that aborts a transaction when the memory never responds.

Parameters:
- TIMEOUT_CYCLES, default 16: maximum BUSY cycles without mem_ready_i before abort. 0 disables the watchdog.
- CNT_WIDTH, default 5: width of the watchdog counter. Must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  3  per-requester request. Bit k is held high until done_o[k] or err_o[k].
- grant_o  output  3  one-hot; the current owner of the memory port.
- done_o  output  3  one-cycle pulse; the owner's transaction completed.
- err_o  output  3  one-cycle pulse; the owner's transaction timed out.
- sel_o  output  2  Mux3 select: 00=req0, 01=req1, 10=req2. 11 is never driven.
- mem_valid_o  output  1  a transaction is presented to the memory.
- mem_ready_i  input  1  the memory accepts/completes the transaction this cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE.
  - grant_o=000, done_o=000, err_o=000.
  - sel_o=00, mem_valid_o=0.
  - watchdog count=0.
  - last-winner pointer=2, so req0 has first priority.
  - No done_o/err_o pulse is produced for a transaction cut off by reset.
- States: IDLE, BUSY.
- IDLE:
  - If req_i != 0, pick a winner by round-robin, searching from (last+1) mod 3 upward and wrapping.
  - On the next edge: grant_o=onehot(winner), sel_o=winner, mem_valid_o=1, count=0, state=BUSY.
  - Grant latency is 1 cycle from first sampled request.
  - mem_ready_i is ignored in IDLE.
- BUSY:
  - grant_o, sel_o and mem_valid_o are held stable.
  - done_o[winner] = mem_ready_i (combinational, same cycle). On that edge: state=IDLE, grant_o=000, mem_valid_o=0, last=winner.
  - Without mem_ready_i, count increments.
  - If TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1 with mem_ready_i=0, then err_o[winner]=1 that cycle. On that edge: return to IDLE exactly as for completion, last=winner.
  - mem_ready_i coincident with the timeout cycle counts as completion: done_o=1, err_o=0.
  - If the owner drops req_i during BUSY, the transaction is not cancelled; done_o/err_o still pulses.
- sel_o keeps the last winner's value while in IDLE. No glitch to 11.
- Back-to-back: there is exactly one IDLE cycle between consecutive transactions. A requester keeping req_i high after its done_o is treated as a new request in that IDLE cycle and loses to any other pending requester.
- Starvation bound: a held request is granted within 2 foreign transactions.
- Invariants:
  - grant_o is one-hot or zero.
  - mem_valid_o == |grant_o.
  - done_o and err_o are each one-hot or zero and never both set.

Decomposition:
- Package arb_pkg holds:
  - NUM_REQ=3.
  - typedef enum {IDLE, BUSY} arb_state_t.
  - Select constants SEL_REQ0=2'b00, SEL_REQ1=2'b01, SEL_REQ2=2'b10.
- One combinational sub-module rr_picker: inputs req[2:0] and last[1:0]; outputs any_req, winner[1:0] and onehot[2:0].
- The data path is not in this block. sel_o feeds the existing Mux3 instances directly.

Test Plan:
- Single request: reset, then req_i=001 at cycle 2. Expect grant_o=001, sel_o=00, mem_valid_o=1 at cycle 3. mem_ready_i=1 at cycle 5 gives done_o=001 in cycle 5, then grant_o=000 at cycle 6.
- Fairness: req_i=111 held throughout, mem_ready_i=1 one cycle after each grant. Grant order is 001, 010, 100, 001. sel_o sequence is 00, 01, 10, 00, with one IDLE cycle between grants.
- Timeout, TIMEOUT_CYCLES=4: req_i=010, mem_ready_i=0. err_o=010 on the 4th BUSY cycle and done_o stays 000. IDLE next cycle. A subsequent req_i=011 is granted to req0 (sel_o=00).
- Ready on the timeout cycle: same setup, but mem_ready_i=1 exactly on the 4th BUSY cycle. Expect done_o=010 and err_o=000.
- Reset mid-transaction: assert rst_ni=0 asynchronously between edges during BUSY. Outputs clear immediately (grant_o=000, mem_valid_o=0, sel_o=00) with no done/err pulse. After release, req_i=110 is granted to req1 first, because the pointer was reset to 2.
- Request dropped during BUSY: req_i=100 granted, then req_i drops to 000. mem_ready_i=1 two cycles later still yields done_o=100, followed by a clean return to IDLE.
